// File: rtl/iwdg_pkg.sv
// rtl/iwdg_pkg.sv - IWDG key values, register offsets and sequencer state encoding
package iwdg_pkg;

  localparam logic [15:0] KEY_ACCESS = 16'h5555;
  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;

  localparam logic [31:0] OFS_KR  = 32'h0;
  localparam logic [31:0] OFS_PR  = 32'h4;
  localparam logic [31:0] OFS_RLR = 32'h8;
  localparam logic [31:0] OFS_ST  = 32'hC;

  typedef enum logic [2:0] {
    IDLE, UNLOCK, WR_PR, WR_RLR, LAUNCH, RUN, KICK, ERR
  } state_e;

endpackage

// File: rtl/iwdg_seq_if.sv
// rtl/iwdg_seq_if.sv - Wishbone master/slave bundle between the sequencer and the IWDG
interface iwdg_seq_if;
  logic [31:0] adr_m2s;
  logic [15:0] dat_m2s;
  logic        cyc_m2s;
  logic        stb_m2s;
  logic        we_m2s;
  logic [15:0] dat_s2m;
  logic        ack_s2m;

  modport master (output adr_m2s, dat_m2s, cyc_m2s, stb_m2s, we_m2s,
                  input  dat_s2m, ack_s2m);
  modport slave  (input  adr_m2s, dat_m2s, cyc_m2s, stb_m2s, we_m2s,
                  output dat_s2m, ack_s2m);
endinterface

// File: rtl/iwdg_seq_xfer.sv
// rtl/iwdg_seq_xfer.sv - single Wishbone transfer engine with ack timeout
module iwdg_seq_xfer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk_m2s,
  input  logic        rst_m2s,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rdata,
  iwdg_seq_if.master  wb
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic          act_q, act_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [15:0]   rdata_q, rdata_d;

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      act_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      act_q   <= act_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  // A completion pulse blocks a new launch for one cycle, guaranteeing the idle gap
  always_comb begin
    act_d   = act_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    rdata_d = rdata_q;
    if (!act_q) begin
      if (req && !done_q && !tmo_q) begin
        act_d = 1'b1;
        adr_d = addr;
        dat_d = wdata;
        we_d  = we;
        cnt_d = '0;
      end
    end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
      act_d = 1'b0;
      adr_d = '0;
      dat_d = '0;
      we_d  = 1'b0;
      tmo_d = 1'b1;
    end else if (wb.ack_s2m) begin
      act_d   = 1'b0;
      adr_d   = '0;
      dat_d   = '0;
      we_d    = 1'b0;
      done_d  = 1'b1;
      rdata_d = wb.dat_s2m;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign wb.cyc_m2s = act_q;
  assign wb.stb_m2s = act_q;
  assign wb.adr_m2s = adr_q;
  assign wb.dat_m2s = dat_q;
  assign wb.we_m2s  = we_q;
  assign done       = done_q;
  assign timeout    = tmo_q;
  assign rdata      = rdata_q;

endmodule

// File: rtl/iwdg_seq.sv
// rtl/iwdg_seq.sv - configures, launches and periodically refreshes an IWDG over Wishbone
// Optional PR/RLR readback verification: define IWDG_SEQ_READBACK_EN
module iwdg_seq import iwdg_pkg::*; #(
  parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          KICK_W      = 16
) (
  input  logic              clk_m2s,
  input  logic              rst_m2s,
  input  logic              start,
  input  logic [2:0]        cfg_pr,
  input  logic [11:0]       cfg_rlr,
  input  logic              kick_en,
  input  logic [KICK_W-1:0] kick_period,
  iwdg_seq_if.master        wb,
  output logic              busy,
  output logic              running,
  output logic              err
);

`ifdef IWDG_SEQ_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [2:0]        pr_q, pr_d;
  logic [11:0]       rlr_q, rlr_d;
  logic [KICK_W-1:0] kcnt_q, kcnt_d;
  logic              rd_q, rd_d;

  logic        x_req, x_we, x_done, x_tmo;
  logic [31:0] x_addr;
  logic [15:0] x_wdata, x_rdata;

  iwdg_seq_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk_m2s (clk_m2s),
    .rst_m2s (rst_m2s),
    .req     (x_req),
    .addr    (x_addr),
    .wdata   (x_wdata),
    .we      (x_we),
    .done    (x_done),
    .timeout (x_tmo),
    .rdata   (x_rdata),
    .wb      (wb)
  );

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      state_q <= IDLE;
      pr_q    <= '0;
      rlr_q   <= '0;
      kcnt_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      rlr_q   <= rlr_d;
      kcnt_q  <= kcnt_d;
      rd_q    <= rd_d;
    end
  end

  // rd_q marks the readback half of WR_PR / WR_RLR
  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    rlr_d   = rlr_q;
    kcnt_d  = kcnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE, ERR: begin
        rd_d   = 1'b0;
        kcnt_d = '0;
        if (start) begin
          state_d = UNLOCK;
          pr_d    = cfg_pr;
          rlr_d   = cfg_rlr;
        end
      end
      UNLOCK: begin
        if (x_tmo)       state_d = ERR;
        else if (x_done) state_d = WR_PR;
      end
      WR_PR: begin
        if (x_tmo) state_d = ERR;
        else if (x_done) begin
          if (RB_EN && !rd_q) rd_d = 1'b1;
          else begin
            rd_d    = 1'b0;
            state_d = (RB_EN && x_rdata[2:0] != pr_q) ? ERR : WR_RLR;
          end
        end
      end
      WR_RLR: begin
        if (x_tmo) state_d = ERR;
        else if (x_done) begin
          if (RB_EN && !rd_q) rd_d = 1'b1;
          else begin
            rd_d    = 1'b0;
            state_d = (RB_EN && x_rdata[11:0] != rlr_q) ? ERR : LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (x_tmo) state_d = ERR;
        else if (x_done) begin
          state_d = RUN;
          kcnt_d  = '0;
        end
      end
      RUN: begin
        if (kick_en && kick_period != '0) begin
          if (kcnt_q == kick_period - KICK_W'(1)) begin
            state_d = KICK;
            kcnt_d  = '0;
          end else begin
            kcnt_d = kcnt_q + KICK_W'(1);
          end
        end else begin
          kcnt_d = '0;
        end
      end
      KICK: begin
        if (x_tmo) state_d = ERR;
        else if (x_done) begin
          state_d = RUN;
          kcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_req   = 1'b0;
    x_addr  = BASE_ADR + OFS_KR;
    x_wdata = '0;
    x_we    = 1'b1;
    case (state_q)
      UNLOCK: begin
        x_req   = 1'b1;
        x_wdata = KEY_ACCESS;
      end
      WR_PR: begin
        x_req   = 1'b1;
        x_addr  = BASE_ADR + OFS_PR;
        x_wdata = {13'b0, pr_q};
        x_we    = !rd_q;
      end
      WR_RLR: begin
        x_req   = 1'b1;
        x_addr  = BASE_ADR + OFS_RLR;
        x_wdata = {4'b0, rlr_q};
        x_we    = !rd_q;
      end
      LAUNCH: begin
        x_req   = 1'b1;
        x_wdata = KEY_START;
      end
      KICK: begin
        x_req   = 1'b1;
        x_wdata = KEY_RELOAD;
      end
      default: x_req = 1'b0;
    endcase
    busy    = state_q inside {UNLOCK, WR_PR, WR_RLR, LAUNCH};
    running = state_q inside {RUN, KICK};
    err     = (state_q == ERR);
  end

endmodule

// File: tb/tb_iwdg_seq.sv
// tb/tb_iwdg_seq.sv - scoreboard bench for iwdg_seq with a Wishbone slave model
module tb_iwdg_seq;

  localparam logic [31:0] BASE = 32'h0100_0000;

  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_pr = '0;
  logic [11:0] cfg_rlr = '0;
  logic        kick_en = 1'b0;
  logic [15:0] kick_period = '0;
  logic        busy, running, err;

  logic        ack_en = 1'b1;
  logic        corrupt_pr = 1'b0;
  logic [15:0] mem [0:3];
  int          cyc_cnt = 0;
  int          n_xfer = 0;
  int          passed = 0;
  int          total = 0;
  exp_t        exp_q[$];
  int          ack_times[$];

  iwdg_seq_if wb();

  iwdg_seq dut (
    .clk_m2s     (clk),
    .rst_m2s     (rst),
    .start       (start),
    .cfg_pr      (cfg_pr),
    .cfg_rlr     (cfg_rlr),
    .kick_en     (kick_en),
    .kick_period (kick_period),
    .wb          (wb),
    .busy        (busy),
    .running     (running),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave: acknowledges one cycle after seeing the strobe
  initial wb.ack_s2m = 1'b0;
  always @(posedge clk) begin
    if (wb.cyc_m2s && wb.stb_m2s && !wb.ack_s2m && ack_en) wb.ack_s2m <= 1'b1;
    else wb.ack_s2m <= 1'b0;
    if (wb.cyc_m2s && wb.stb_m2s && wb.ack_s2m && wb.we_m2s) mem[wb.adr_m2s[3:2]] <= wb.dat_m2s;
  end
  assign wb.dat_s2m = (wb.adr_m2s[3:2] == 2'd1 && corrupt_pr) ? 16'h0002 : mem[wb.adr_m2s[3:2]];

  // Scoreboard: each completed handshake pops one expected transfer
  always @(negedge clk) begin
    if (wb.cyc_m2s && wb.stb_m2s && wb.ack_s2m) begin
      exp_t e;
      n_xfer++;
      ack_times.push_back(cyc_cnt);
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected adr=%h dat=%h we=%b", wb.adr_m2s, wb.dat_m2s, wb.we_m2s);
      end else begin
        e = exp_q.pop_front();
        if (wb.adr_m2s !== e.adr || wb.we_m2s !== e.we || (e.we && wb.dat_m2s !== e.dat))
          $display("FAIL sb_xfer got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                   wb.adr_m2s, wb.dat_m2s, wb.we_m2s, e.adr, e.dat, e.we);
        else passed++;
      end
    end
  end

  task automatic push_exp(input logic [31:0] adr, input logic [15:0] dat, input logic we);
    exp_t e;
    e.adr = adr; e.dat = dat; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg(input logic [2:0] pr, input logic [11:0] rlr);
    push_exp(BASE + 32'h0, 16'h5555, 1'b1);
    push_exp(BASE + 32'h4, {13'b0, pr}, 1'b1);
`ifdef IWDG_SEQ_READBACK_EN
    push_exp(BASE + 32'h4, 16'h0, 1'b0);
`endif
    push_exp(BASE + 32'h8, {4'b0, rlr}, 1'b1);
`ifdef IWDG_SEQ_READBACK_EN
    push_exp(BASE + 32'h8, 16'h0, 1'b0);
`endif
    push_exp(BASE + 32'h0, 16'hCCCC, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ack_times.delete();
  endtask

  task automatic pulse_start(input logic [2:0] pr, input logic [11:0] rlr);
    cfg_pr = pr; cfg_rlr = rlr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_running(input string name);
    for (int i = 0; i < 300 && !running; i++) @(negedge clk);
    total++;
    if (running !== 1'b1) $display("FAIL %s running=%b want 1", name, running);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL %s_sb_left pending=%0d want 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({wb.adr_m2s, wb.dat_m2s, wb.cyc_m2s, wb.stb_m2s, wb.we_m2s, busy, running, err} !== '0)
      $display("FAIL reset_outputs adr=%h dat=%h cyc=%b stb=%b we=%b busy=%b run=%b err=%b want all 0",
               wb.adr_m2s, wb.dat_m2s, wb.cyc_m2s, wb.stb_m2s, wb.we_m2s, busy, running, err);
    else passed++;
  endtask

  task automatic test_config();
    push_cfg(3'b001, 12'h001);
    @(negedge clk);
    pulse_start(3'b001, 12'h001);
    total++;
    if (busy !== 1'b1) $display("FAIL cfg_busy busy=%b want 1", busy);
    else passed++;
    repeat (3) @(negedge clk);
    pulse_start(3'b111, 12'hFFF);
    cfg_pr = 3'b110; cfg_rlr = 12'hABC;
    wait_running("cfg");
    total++;
    if (busy !== 1'b0) $display("FAIL cfg_busy_done busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic kick_run(input logic [15:0] period, input int n, input int gap, input string name);
    int base;
    ack_times.delete();
    kick_period = period;
    for (int i = 0; i < n; i++) push_exp(BASE, 16'hAAAA, 1'b1);
    kick_en = 1'b1;
    for (int i = 0; i < 400 && ack_times.size() < n; i++) @(negedge clk);
    kick_en = 1'b0;
    total++;
    if (ack_times.size() < n) begin
      $display("FAIL %s_count kicks=%0d want %0d", name, ack_times.size(), n);
    end else begin
      passed++;
      for (int i = 1; i < n; i++) begin
        total++;
        if (ack_times[i] - ack_times[i-1] != gap)
          $display("FAIL %s_interval got=%0d want=%0d", name, ack_times[i] - ack_times[i-1], gap);
        else passed++;
      end
    end
  endtask

  // Kick spacing = kick_period RUN cycles + KICK entry, request, 1-cycle slave ack, return
  task automatic test_kick();
    int n0;
    kick_run(16'd10, 3, 14, "kick10");
    n0 = n_xfer;
    repeat (40) @(negedge clk);
    total++;
    if (n_xfer != n0 || exp_q.size() != 0)
      $display("FAIL kick_off xfers=%0d want %0d pending=%0d", n_xfer, n0, exp_q.size());
    else passed++;
    kick_period = 16'd0;
    kick_en = 1'b1;
    pulse_start(3'b011, 12'h222);
    repeat (40) @(negedge clk);
    kick_en = 1'b0;
    total++;
    if (n_xfer != n0 || running !== 1'b1 || busy !== 1'b0)
      $display("FAIL kick_period0 xfers=%0d want %0d running=%b busy=%b", n_xfer, n0, running, busy);
    else passed++;
    kick_run(16'd1, 3, 5, "kick1");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    ack_en = 1'b0;
    pulse_start(3'b010, 12'h010);
    for (int i = 0; i < 10 && !wb.stb_m2s; i++) @(negedge clk);
    hi = 0;
    while (wb.stb_m2s && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    total++;
    if (hi != 17) $display("FAIL tmo_stb_len got=%0d want=17", hi);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || running !== 1'b0)
      $display("FAIL tmo_flags err=%b busy=%b run=%b want 1/0/0", err, busy, running);
    else passed++;
    ack_en = 1'b1;
    push_cfg(3'b101, 12'h345);
    pulse_start(3'b101, 12'h345);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_restart err=%b busy=%b want 0/1", err, busy);
    else passed++;
    wait_running("tmo_restart");
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    push_exp(BASE + 32'h0, 16'h5555, 1'b1);
    push_exp(BASE + 32'h4, 16'h0004, 1'b1);
`ifdef IWDG_SEQ_READBACK_EN
    push_exp(BASE + 32'h4, 16'h0, 1'b0);
`endif
    pulse_start(3'b100, 12'h777);
    for (i = 0; i < 100 && !(wb.stb_m2s && wb.we_m2s && wb.adr_m2s == BASE + 32'h8); i++) @(negedge clk);
    total++;
    if (i >= 100) $display("FAIL rst_mid_reach no RLR write seen");
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({wb.adr_m2s, wb.dat_m2s, wb.cyc_m2s, wb.stb_m2s, wb.we_m2s, busy, running, err} !== '0)
      $display("FAIL rst_mid_outputs adr=%h cyc=%b stb=%b busy=%b want all 0",
               wb.adr_m2s, wb.cyc_m2s, wb.stb_m2s, busy);
    else passed++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || wb.cyc_m2s !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rst_mid_idle busy=%b cyc=%b pending=%0d want 0/0/0", busy, wb.cyc_m2s, exp_q.size());
    else passed++;
  endtask

`ifdef IWDG_SEQ_READBACK_EN
  task automatic test_readback();
    int n0;
    do_reset();
    corrupt_pr = 1'b1;
    n0 = n_xfer;
    push_exp(BASE + 32'h0, 16'h5555, 1'b1);
    push_exp(BASE + 32'h4, 16'h0001, 1'b1);
    push_exp(BASE + 32'h4, 16'h0, 1'b0);
    pulse_start(3'b001, 12'h001);
    repeat (40) @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || n_xfer - n0 != 3 || exp_q.size() != 0)
      $display("FAIL readback_err err=%b busy=%b xfers=%0d want 1/0/3", err, busy, n_xfer - n0);
    else passed++;
    corrupt_pr = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_config();
    test_kick();
    test_timeout();
    test_reset_mid();
`ifdef IWDG_SEQ_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
